// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage data-memory initiator. Checks alignment, steers byte
// lanes onto a req/gnt/rvalid bus, extends load data and aborts stuck accesses.
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        stall,
  output logic        done,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // TIMEOUT >= 2, so the counter only ever needs to hold 0..TIMEOUT-1.
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_load;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic [1:0]    lat_lane;

  logic          misaligned;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   ld_ext;
  logic          complete;
  logic          expire;

  assign stall = (state == S_IDLE && op_valid) || state == S_REQ || state == S_WAIT;

  // Request-side decode of the incoming op; size 3 behaves as a word.
  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = op_wdata;
    case (op_size)
      2'd1: begin
        misaligned = op_addr[0];
        be_calc    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{op_wdata[15:0]}};
      end
      2'd2: begin
        be_calc    = 4'b0001 << op_addr[1:0];
        wdata_calc = {4{op_wdata[7:0]}};
      end
      default: misaligned = |op_addr[1:0];
    endcase
  end

  always_comb begin
    half_sel = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_lane)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    case (lat_size)
      2'd1:    ld_ext = lat_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'd2:    ld_ext = lat_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: ld_ext = mem_rdata;
    endcase
  end

  // A response landing on the last allowed cycle beats the timeout.
  assign complete = (state == S_REQ && mem_gnt && mem_rvalid) || (state == S_WAIT && mem_rvalid);
  assign expire   = (state == S_REQ || state == S_WAIT) && cnt == CW'(TIMEOUT - 1) && !complete;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      done         <= 1'b0;
      ld_valid     <= 1'b0;
      ld_data      <= '0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      lat_load     <= 1'b0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_lane     <= '0;
    end else begin
      done     <= 1'b0;
      ld_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (misaligned) begin
              state    <= S_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state        <= S_REQ;
              cnt          <= '0;
              mem_req      <= 1'b1;
              mem_we       <= ~op_load;
              mem_addr     <= {op_addr[31:2], 2'b00};
              mem_be       <= be_calc;
              mem_wdata    <= wdata_calc;
              lat_load     <= op_load;
              lat_size     <= op_size;
              lat_unsigned <= op_unsigned;
              lat_lane     <= op_addr[1:0];
            end
          end
        end
        S_REQ, S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (complete) begin
            state   <= S_DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
            if (lat_load) begin
              ld_valid <= 1'b1;
              ld_data  <= ld_ext;
            end
          end else if (expire) begin
            state   <= S_DONE;
            done    <= 1'b1;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
          end else if (state == S_REQ && mem_gnt) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized accesses against a byte-lane
// arithmetic model of alignment, lane steering, extension and timeout.
module tb_mem_access_unit;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_load;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        stall;
  logic        done;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ld_data = 32'h0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_load(op_load),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
    .op_wdata(op_wdata), .stall(stall), .done(done), .ld_valid(ld_valid),
    .ld_data(ld_data), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int nbytes_of(logic [1:0] size);
    case (size)
      2'd1:    return 2;
      2'd2:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_misaligned(logic [1:0] size, logic [31:0] addr);
    return (addr % 32'(nbytes_of(size))) != 32'd0;
  endfunction

  function automatic logic [3:0] model_be(logic [1:0] size, logic [31:0] addr);
    logic [3:0] m;
    m = 4'((1 << nbytes_of(size)) - 1);
    return m << int'(addr % 32'd4);
  endfunction

  function automatic logic [31:0] model_wdata(logic [1:0] size, logic [31:0] wdata);
    logic [31:0] r;
    int n;
    n = nbytes_of(size);
    r = 32'h0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wdata[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] size, bit uns,
                                             logic [31:0] addr);
    int bits;
    logic [31:0] mask;
    logic [31:0] v;
    bits = 8 * nbytes_of(size);
    v = word >> (8 * int'(addr % 32'd4));
    if (bits < 32) begin
      mask = (32'd1 << bits) - 32'd1;
      v = v & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_ld_valid"}, 32'(ld_valid), 32'd0);
    check_output({tag, "_ld_data"}, ld_data, 32'd0);
    check_output({tag, "_misalign"}, 32'(misalign), 32'd0);
    check_output({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    check_output({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_output({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_output({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // One op: the memory grants g request cycles in and answers r cycles after the grant.
  task automatic apply_stimulus(input bit load, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int g, input int r,
                                input bit late_rv);
    bit mis;
    bit ok;
    bit seen_done;
    int c;
    int exp_it;
    mis = is_misaligned(size, addr);
    c = g + r;
    ok = !mis && (c <= TIMEOUT - 1);
    exp_it = mis ? 0 : ((c <= TIMEOUT - 1) ? c + 1 : TIMEOUT);
    @(negedge clk);
    op_valid = 1'b1; op_load = load; op_size = size; op_unsigned = uns;
    op_addr = addr; op_wdata = wdata;
    #1;
    check_output("stall_on_op", 32'(stall), 32'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 3 * TIMEOUT && !seen_done; i++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      if (done) begin
        seen_done = 1'b1;
        check_output("done_cycle", 32'(i), 32'(exp_it));
        check_output("stall_in_done", 32'(stall), 32'd0);
        check_output("misalign", 32'(misalign), 32'(mis));
        check_output("bus_err", 32'(bus_err), 32'(!mis && !ok));
        check_output("ld_valid", 32'(ld_valid), 32'(ok && load));
        if (ok && load) exp_ld_data = model_load(rdata, size, uns, addr);
        check_output("ld_data", ld_data, exp_ld_data);
        check_output("req_in_done", 32'(mem_req), 32'd0);
      end else begin
        check_output("stall_busy", 32'(stall), 32'd1);
        check_output("mem_req", 32'(mem_req), 32'(i <= g));
        if (i <= g) begin
          check_output("mem_we", 32'(mem_we), 32'(!load));
          check_output("mem_addr", mem_addr, addr - (addr % 32'd4));
          check_output("mem_be", 32'(mem_be), 32'(model_be(size, addr)));
          check_output("mem_wdata", mem_wdata, model_wdata(size, wdata));
        end
        mem_gnt = (i == g);
        mem_rvalid = (i == c);
        mem_rdata = (i == c) ? rdata : $urandom;
      end
    end
    check_output("done_seen", 32'(seen_done), 32'd1);
    if (late_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_output("idle_done", 32'(done), 32'd0);
    check_output("idle_ld_valid", 32'(ld_valid), 32'd0);
    check_output("idle_misalign", 32'(misalign), 32'd0);
    check_output("idle_bus_err", 32'(bus_err), 32'd0);
    check_output("idle_mem_req", 32'(mem_req), 32'd0);
    check_output("idle_ld_data", ld_data, exp_ld_data);
    op_valid = 1'b0;
    #1;
    check_output("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  size;
    logic [31:0] addr;
    int          g;
    reset = 1'b1; op_valid = 1'b0; op_load = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    op_addr = 32'h0; op_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    $display("[TB] byte loads on a zero-latency memory");
    apply_stimulus(1'b1, 2'd2, 1'b0, 32'h103, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
    check_output("lb_value", ld_data, 32'hFFFFFF80);
    apply_stimulus(1'b1, 2'd2, 1'b1, 32'h103, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
    check_output("lbu_value", ld_data, 32'h00000080);

    $display("[TB] half store with delayed ack");
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h206, 32'h1234ABCD, 32'h0, 0, 2, 1'b0);

    $display("[TB] misaligned word and half");
    apply_stimulus(1'b1, 2'd0, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    apply_stimulus(1'b1, 2'd1, 1'b0, 32'h103, 32'h0, 32'h0, 0, 0, 1'b0);

    $display("[TB] variable latency and timeout");
    apply_stimulus(1'b1, 2'd1, 1'b0, 32'h302, 32'h0, 32'hC0DE8001, 3, 2, 1'b0);
    apply_stimulus(1'b1, 2'd0, 1'b0, 32'h400, 32'h0, 32'h12345678, 100, 0, 1'b1);
    apply_stimulus(1'b1, 2'd0, 1'b0, 32'h404, 32'h0, 32'hA5A5A5A5, 4, 3, 1'b0);

    $display("[TB] reset in the middle of a load");
    @(negedge clk);
    op_valid = 1'b1; op_load = 1'b1; op_size = 2'd0; op_unsigned = 1'b0; op_addr = 32'h100;
    @(negedge clk);
    #1;
    check_output("rst_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check_output("rst_wait_stall", 32'(stall), 32'd1);
    reset = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("rst_mid");
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01;
    exp_ld_data = 32'h0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_output("stray_done", 32'(done), 32'd0);
    check_output("stray_ld_valid", 32'(ld_valid), 32'd0);
    apply_stimulus(1'b1, 2'd0, 1'b0, 32'h100, 32'h0, 32'h80FF7F01, 0, 0, 1'b0);
    check_output("lw_after_reset", ld_data, 32'h80FF7F01);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % 32'(nbytes_of(size)));
      g = ($urandom_range(0, 9) == 0) ? 50 : int'($urandom_range(0, 5));
      apply_stimulus(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
                     $urandom, $urandom, g, int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
